// File: rtl/bcd_mac_seq.sv
// ---------------------------------------------------------------------------
// bcd_mac_seq
//
// Sequencing controller for one external 4-digit BCD accumulator. A START
// accepted in IDLE runs one accumulation:
//   CLEAR : pulse ACC_CLR to zero the accumulator
//   FETCH : take one two-digit BCD product over the P_* handshake
//   ADD   : pulse ACC_EN so the accumulator adds ACC_D
//   CAPT  : copy the finished 4-digit sum from ACC_Q into R_DATA
//   DONE  : offer R_DATA over the R_* handshake
// FETCH/ADD repeat NTERMS times before CAPT.
//
// Handshakes (both sides): a transfer happens on a rising CLK edge where
// valid and ready are both high. A valid that is raised stays high, with its
// data stable, until that transfer. P_RDY and R_VALID come straight from
// registers, so they never depend combinationally on P_VALID or R_RDY.
//
// Ports
//   CLK        system clock, all state on the rising edge
//   CLR        asynchronous, active-low reset
//   START      start one accumulation (sampled only in IDLE)
//   BUSY       high in every state except IDLE
//   P_DATA     product: [7:4] tens digit, [3:0] units digit
//   P_VALID    P_DATA valid
//   P_RDY      controller takes P_DATA this cycle
//   ACC_D      registered operand to the accumulator
//   ACC_CLR    synchronous accumulator clear, active high
//   ACC_EN     accumulator load enable
//   ACC_Q      accumulator output, 4 BCD digits, [3:0] least significant
//   R_DATA     captured result
//   R_VALID    R_DATA valid
//   R_RDY      consumer takes R_DATA
//   ERR        sticky: a non-BCD digit arrived during this run
//   DBG_STATE  current FSM state encoding
//   DBG_CNT    current term counter
// ---------------------------------------------------------------------------
module bcd_mac_seq #(
    parameter int NTERMS = 3
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        START,
    output logic        BUSY,
    input  logic [7:0]  P_DATA,
    input  logic        P_VALID,
    output logic        P_RDY,
    output logic [7:0]  ACC_D,
    output logic        ACC_CLR,
    output logic        ACC_EN,
    input  logic [15:0] ACC_Q,
    output logic [15:0] R_DATA,
    output logic        R_VALID,
    input  logic        R_RDY,
    output logic        ERR,
    output logic [2:0]  DBG_STATE,
    output logic [3:0]  DBG_CNT
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FETCH = 3'd2,
        S_ADD   = 3'd3,
        S_CAPT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [3:0] LAST_TERM = 4'(NTERMS);

    state_t     state;
    logic [3:0] cnt;
    logic [3:0] cnt_inc;
    logic       bad_digit;
    logic       p_take;

    assign cnt_inc   = cnt + 4'd1;
    assign bad_digit = (P_DATA[7:4] > 4'd9) || (P_DATA[3:0] > 4'd9);
    assign p_take    = P_VALID && P_RDY;

    assign DBG_STATE = state;
    assign DBG_CNT   = cnt;

    // The Moore outputs are registered and updated together with the state,
    // so each one always equals a decode of the current state:
    //   BUSY = !IDLE, ACC_CLR = CLEAR, P_RDY = FETCH, ACC_EN = ADD,
    //   R_VALID = DONE.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            BUSY    <= 1'b0;
            P_RDY   <= 1'b0;
            ACC_CLR <= 1'b0;
            ACC_EN  <= 1'b0;
            ACC_D   <= 8'h00;
            R_DATA  <= 16'h0000;
            R_VALID <= 1'b0;
            ERR     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START) begin
                        state   <= S_CLEAR;
                        cnt     <= 4'd0;
                        ERR     <= 1'b0;
                        BUSY    <= 1'b1;
                        ACC_CLR <= 1'b1;
                    end
                end

                S_CLEAR: begin
                    state   <= S_FETCH;
                    ACC_CLR <= 1'b0;
                    P_RDY   <= 1'b1;
                end

                S_FETCH: begin
                    if (p_take) begin
                        // A malformed product still counts as a term but
                        // contributes zero, so the sum stays valid BCD.
                        if (bad_digit) begin
                            ACC_D <= 8'h00;
                            ERR   <= 1'b1;
                        end else begin
                            ACC_D <= P_DATA;
                        end
                        state  <= S_ADD;
                        P_RDY  <= 1'b0;
                        ACC_EN <= 1'b1;
                    end
                end

                S_ADD: begin
                    cnt    <= cnt_inc;
                    ACC_EN <= 1'b0;
                    if (cnt_inc == LAST_TERM) begin
                        state <= S_CAPT;
                    end else begin
                        state <= S_FETCH;
                        P_RDY <= 1'b1;
                    end
                end

                S_CAPT: begin
                    // The accumulator loaded on the edge that ended ADD, so
                    // ACC_Q already holds the complete sum here.
                    R_DATA  <= ACC_Q;
                    state   <= S_DONE;
                    R_VALID <= 1'b1;
                end

                S_DONE: begin
                    if (R_RDY) begin
                        state   <= S_IDLE;
                        R_VALID <= 1'b0;
                        BUSY    <= 1'b0;
                    end
                end

                default: begin
                    state   <= S_IDLE;
                    BUSY    <= 1'b0;
                    P_RDY   <= 1'b0;
                    ACC_CLR <= 1'b0;
                    ACC_EN  <= 1'b0;
                    R_VALID <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_mac_seq.sv
module tb_bcd_mac_seq;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic [7:0]  p_data = 8'h00;
  logic        p_valid = 1'b0;
  logic        p_rdy;
  logic [7:0]  acc_d;
  logic        acc_clr;
  logic        acc_en;
  logic [15:0] acc_q = 16'h0000;
  logic [15:0] r_data;
  logic        r_valid;
  logic        r_rdy = 1'b0;
  logic        err;
  logic [2:0]  dbg_state;
  logic [3:0]  dbg_cnt;

  always #5 clk = ~clk;

  bcd_mac_seq #(.NTERMS(3)) dut (
    .CLK(clk), .CLR(clr), .START(start), .BUSY(busy),
    .P_DATA(p_data), .P_VALID(p_valid), .P_RDY(p_rdy),
    .ACC_D(acc_d), .ACC_CLR(acc_clr), .ACC_EN(acc_en), .ACC_Q(acc_q),
    .R_DATA(r_data), .R_VALID(r_valid), .R_RDY(r_rdy), .ERR(err),
    .DBG_STATE(dbg_state), .DBG_CNT(dbg_cnt)
  );

  // ---------------- external accumulator model ----------------
  function automatic logic [15:0] bcd_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic [4:0]  s;
    logic        c;
    r = 16'h0000;
    c = 1'b0;
    for (int d = 0; d < 4; d++) begin
      s = {1'b0, a[d*4 +: 4]} + {1'b0, b[d*4 +: 4]} + {4'b0000, c};
      if (s > 5'd9) begin
        s = s + 5'd6;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      r[d*4 +: 4] = s[3:0];
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (acc_clr) acc_q <= 16'h0000;
    else if (acc_en) acc_q <= bcd_add(acc_q, {8'h00, acc_d});
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},    32'(busy),    32'd0);
    check({tag, "_p_rdy"},   32'(p_rdy),   32'd0);
    check({tag, "_acc_clr"}, 32'(acc_clr), 32'd0);
    check({tag, "_acc_en"},  32'(acc_en),  32'd0);
    check({tag, "_acc_d"},   32'(acc_d),   32'd0);
    check({tag, "_r_data"},  32'(r_data),  32'd0);
    check({tag, "_r_valid"}, 32'(r_valid), 32'd0);
    check({tag, "_err"},     32'(err),     32'd0);
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge while the DUT is in IDLE (that is cycle 0).
  // Returns at the falling edge of the IDLE cycle following the result handshake.
  task automatic run(input logic [7:0] t0, input logic [7:0] t1, input logic [7:0] t2,
                     input int stall_idx, input int stall_len, input int rdy_wait,
                     input bit pulse_start, input bit hold_start,
                     output int rv_cyc, output logic [15:0] res,
                     output int n_en, output int n_clr, output int n_rv,
                     output logic err_seen, output logic err_c1, output logic [7:0] accd0);
    logic [7:0] terms [3];
    logic [1:0] sel;
    int idx, st, cyc;
    bit fin;
    terms = '{t0, t1, t2};
    idx = 0; st = 0; cyc = 0; fin = 0;
    rv_cyc = -1; res = 16'h0000; n_en = 0; n_clr = 0; n_rv = 0;
    err_seen = 1'b0; err_c1 = 1'b0; accd0 = 8'h00;
    p_data = t0;
    p_valid = 1'b1;
    r_rdy = 1'b0;
    start = 1'b1;
    while (cyc < 100 && !fin) begin
      @(negedge clk);
      cyc++;
      start = hold_start;
      if (cyc == 1) begin
        check("clear_in_cycle1", 32'(acc_clr), 32'd1);
        err_c1 = err;
      end
      if (acc_clr) n_clr++;
      if (acc_en) begin
        n_en++;
        if (n_en == 1) accd0 = acc_d;
        idx++;
        sel = (idx < 3) ? 2'(idx) : 2'd0;
        p_data = terms[sel];
        if (idx == stall_idx && stall_len > 0) begin
          st = stall_len;
          p_valid = 1'b0;
        end
      end else if (st > 0) begin
        check("p_rdy_during_stall", 32'(p_rdy), 32'd1);
        st--;
      end else begin
        p_valid = 1'b1;
      end
      if (r_valid) begin
        if (n_rv == 0) begin
          rv_cyc = cyc;
          res = r_data;
          err_seen = err;
        end else begin
          check("r_data_stable", 32'(r_data), 32'(res));
        end
        if (pulse_start && n_rv == 2) start = 1'b1;
        r_rdy = (n_rv >= rdy_wait);
        n_rv++;
      end else if (n_rv > 0) begin
        check("idle_after_handshake", 32'(busy), 32'd0);
        r_rdy = 1'b0;
        fin = 1;
      end else begin
        r_rdy = 1'b0;
      end
    end
    if (!fin) check("run_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  int rv_cyc, n_en, n_clr, n_rv;
  logic [15:0] res, res_a;
  logic err_seen, err_c1;
  logic [7:0] accd0;

  initial begin
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    clr = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 32'(dbg_state), 32'd0);

    // Plain run, no stalls: 12 + 45 + 99 = 156
    run(8'h12, 8'h45, 8'h99, -1, 0, 0, 0, 0,
        rv_cyc, res, n_en, n_clr, n_rv, err_seen, err_c1, accd0);
    check("t1_result", 32'(res), 32'h0156);
    check("t1_rv_cycle", 32'(rv_cyc), 32'd9);
    check("t1_err", 32'(err_seen), 32'd0);
    check("t1_acc_en_pulses", 32'(n_en), 32'd3);
    check("t1_acc_clr_pulses", 32'(n_clr), 32'd1);
    check("t1_r_valid_cycles", 32'(n_rv), 32'd1);

    // 99 * 3 = 297, four stall cycles before term 2
    run(8'h99, 8'h99, 8'h99, 2, 4, 0, 0, 0,
        rv_cyc, res, n_en, n_clr, n_rv, err_seen, err_c1, accd0);
    check("t2_result", 32'(res), 32'h0297);
    check("t2_rv_cycle", 32'(rv_cyc), 32'd13);

    // 0x3A is not BCD: counts as zero and sets ERR; 20 + 5 = 25
    run(8'h3A, 8'h20, 8'h05, -1, 0, 0, 0, 0,
        rv_cyc, res, n_en, n_clr, n_rv, err_seen, err_c1, accd0);
    check("t3_err", 32'(err_seen), 32'd1);
    check("t3_acc_d_term0", 32'(accd0), 32'h00);
    check("t3_result", 32'(res), 32'h0025);
    check("t3_acc_en_pulses", 32'(n_en), 32'd3);
    check("t3_err_sticky_idle", 32'(err), 32'd1);

    // Result held 5 cycles, START pulsed during DONE: 11 + 22 + 33 = 66
    run(8'h11, 8'h22, 8'h33, -1, 0, 5, 1, 0,
        rv_cyc, res, n_en, n_clr, n_rv, err_seen, err_c1, accd0);
    check("t4_err_cleared", 32'(err_c1), 32'd0);
    check("t4_result", 32'(res), 32'h0066);
    check("t4_rv_cycle", 32'(rv_cyc), 32'd9);
    check("t4_r_valid_cycles", 32'(n_rv), 32'd6);
    check("t4_acc_clr_pulses", 32'(n_clr), 32'd1);
    @(negedge clk);
    check("t4_start_ignored_clr", 32'(acc_clr), 32'd0);
    check("t4_start_ignored_busy", 32'(busy), 32'd0);

    // Reset in the second ADD cycle, then a fresh run: 1 + 2 + 3 = 6
    p_data = 8'h50;
    p_valid = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("t5_in_second_add", 32'(acc_en), 32'd1);
    clr = 1'b0;
    #1;
    check_reset_outputs("t5_abort");
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    run(8'h01, 8'h02, 8'h03, -1, 0, 0, 0, 0,
        rv_cyc, res, n_en, n_clr, n_rv, err_seen, err_c1, accd0);
    check("t5_result", 32'(res), 32'h0006);
    check("t5_rv_cycle", 32'(rv_cyc), 32'd9);

    // Back-to-back runs with START held: 7+8+9 = 24, then 10+20+30 = 60
    run(8'h07, 8'h08, 8'h09, -1, 0, 0, 0, 1,
        rv_cyc, res_a, n_en, n_clr, n_rv, err_seen, err_c1, accd0);
    check("t6_first_result", 32'(res_a), 32'h0024);
    check("t6_first_clr_pulses", 32'(n_clr), 32'd1);
    run(8'h10, 8'h20, 8'h30, -1, 0, 0, 0, 0,
        rv_cyc, res, n_en, n_clr, n_rv, err_seen, err_c1, accd0);
    check("t6_second_result", 32'(res), 32'h0060);
    check("t6_second_rv_cycle", 32'(rv_cyc), 32'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bcd_mac_seq.md
# bcd_mac_seq

Sequencing controller for the 4-digit BCD accumulator in the matrix multiplier datapath. On a start request it clears the accumulator, pulls NTERMS two-digit BCD products from the multiplier stage over a valid/ready handshake, and gates each one into the accumulator. It then captures the 4-digit sum and presents it as one matrix element on an output valid/ready handshake. Each instance of this block owns one accumulator; the accumulator itself is external.

## Interface
- NTERMS, 3, number of products summed per result (1..15; 3 for a 3x3 matrix)
- CLK  in  1  system clock, all state on rising edge
- CLR  in  1  asynchronous, active-low reset
- START  in  1  begin one accumulation; sampled only in IDLE
- BUSY  out  1  high in every state except IDLE
- P_DATA  in  8  product, [7:4] tens digit, [3:0] units digit
- P_VALID  in  1  P_DATA valid
- P_RDY  out  1  controller accepts P_DATA this cycle
- ACC_D  out  8  registered operand to accumulator ([7:4] to IH, [3:0] to IL)
- ACC_CLR  out  1  synchronous clear to accumulator, active-high
- ACC_EN  out  1  accumulator load enable (gates the accumulator's clock/enable)
- ACC_Q  in  16  accumulator output, 4 BCD digits, [3:0] least significant
- R_DATA  out  16  captured result
- R_VALID  out  1  R_DATA valid
- R_RDY  in  1  consumer accepts R_DATA
- ERR  out  1  sticky: a non-BCD digit was received in this run

## Operation
- States: IDLE, CLEAR, FETCH, ADD, CAPT, DONE. Term counter CNT has 4 bits.
- IDLE: START=1 -> CLEAR. ERR<=0, CNT<=0. START=0 -> stay.
- CLEAR: ACC_CLR=1 for exactly one cycle -> FETCH.
- FETCH: P_RDY=1. On P_VALID&P_RDY: ACC_D<=P_DATA -> ADD. Otherwise stay, with P_RDY held high.
- Non-BCD check on acceptance: either nibble >9 -> ACC_D<=8'h00, ERR<=1. The term still counts.
- ADD: ACC_EN=1 for one cycle, CNT<=CNT+1. Next state is CAPT if CNT+1==NTERMS, else FETCH.
- CAPT: R_DATA<=ACC_Q -> DONE. ACC_Q already holds the final sum because the accumulator loaded on the edge that ended ADD.
- DONE: R_VALID=1, R_DATA stable. On R_RDY -> IDLE.
- START outside IDLE: ignored, not queued.
- ACC_CLR, ACC_EN, P_RDY and R_VALID are decoded from the state register only (Moore). They must not depend combinationally on inputs.
- Accumulator overflow beyond 9999 wraps modulo 10000 in the accumulator. The controller neither detects nor flags it.
- ERR holds until the next START is accepted. R_DATA holds until the next CAPT.

## Timing
- Reset (CLR=0, asynchronous): state IDLE, CNT=0, BUSY=0, P_RDY=0, ACC_CLR=0, ACC_EN=0, ACC_D=0, R_DATA=0, R_VALID=0, ERR=0.
- Reset mid-run: the run is abandoned immediately, with no partial result. The accumulator is cleared by the CLEAR state of the next run.
- Cycle numbering: START is sampled high in IDLE at the edge ending cycle 0.
  - Cycle 1: CLEAR.
  - Term i (0-based), no stalls: FETCH in cycle 2+2i, ADD in cycle 3+2i.
  - CAPT in cycle 2·NTERMS+2.
  - R_VALID first high in cycle 2·NTERMS+3 (cycle 9 for NTERMS=3).
- Each P_VALID stall cycle adds one cycle.
- Throughput: one product per 2 cycles maximum. P_RDY is low during ADD.
- DONE with R_RDY high in its first cycle: R_VALID is high for exactly one cycle. IDLE follows, and START can be accepted in that IDLE cycle.
- BUSY is high from cycle 1 through the last DONE cycle.

## Test plan
- Reset then START with terms 0x12, 0x45, 0x99 (P_VALID always high, R_RDY=1), bench accumulator model attached -> R_DATA=16'h0156 with R_VALID in cycle 9, ERR=0, exactly 3 ACC_EN pulses and 1 ACC_CLR pulse.
- Terms 0x99 ×3, with P_VALID dropped for 4 cycles before term 2 -> P_RDY held high through the stall, R_DATA=16'h0297 with R_VALID in cycle 13.
- Terms 0x3A, 0x20, 0x05 -> ERR=1, ACC_D=0x00 for term 0, R_DATA=16'h0025. The next START clears ERR.
- R_RDY low for 5 cycles in DONE, with START pulsed during DONE -> R_VALID and R_DATA stable throughout. START ignored, so no new ACC_CLR appears. IDLE is entered on the cycle after R_RDY rises.
- CLR asserted during the second ADD -> all outputs at their reset values within the same cycle. A new run with 0x01, 0x02, 0x03 then gives 16'h0006.
- Back-to-back runs with START held high: second run's CLEAR immediately follows the handshake IDLE cycle, and the second result is independent of the first.
